// File: rtl/tmr_ctrl.sv
// Register-bus sequencer for one tmr instance: programs CR/RE on start, clears and counts interrupts, disables on stop.
// Optional CR readback check after programming is built when TMR_CTRL_VERIFY_EN is defined.
module tmr_ctrl #(
    parameter int         tmr_w   = 8,
    parameter logic [4:0] CR_ADDR = 5'h00,
    parameter logic [4:0] RE_ADDR = 5'h04,
    parameter logic [4:0] IR_ADDR = 5'h08
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             stop,
    input  logic [31:0]      cfg_cr,
    input  logic [tmr_w-1:0] cfg_re,
    input  logic [15:0]      ev_num,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [15:0]      ev_cnt,
    output logic [4:0]       tmr_addr,
    output logic             tmr_we,
    output logic [31:0]      tmr_wd,
    input  logic [31:0]      tmr_rd,
    input  logic             tmr_irq
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_CR,
`ifdef TMR_CTRL_VERIFY_EN
        S_RD_CR,
`endif
        S_WR_RE,
        S_WAIT_IRQ,
        S_CLR_IR,
        S_GUARD,
        S_STOP_CR,
        S_DONE
    } state_t;

    state_t      r_state;
    logic        r_busy;
    logic        r_done;
    logic [15:0] r_ev_cnt;
    logic [15:0] r_ev_num;
    logic [4:0]  r_addr;
    logic        r_we;
    logic [31:0] r_wd;
    logic [31:0] w_re_ext;

    assign w_re_ext = 32'(cfg_re);

`ifdef TMR_CTRL_VERIFY_EN
    logic r_err;
    assign err = r_err;
`else
    logic w_unused_rd;
    assign w_unused_rd = ^tmr_rd;
    assign err         = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_ev_cnt <= 16'h0;
            r_ev_num <= 16'h0;
            r_addr   <= 5'h0;
            r_we     <= 1'b0;
            r_wd     <= 32'h0;
`ifdef TMR_CTRL_VERIFY_EN
            r_err    <= 1'b0;
`endif
        end else begin
            // Write strobe and done are single-cycle unless a state re-asserts them.
            r_we   <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state  <= S_WR_CR;
                        r_busy   <= 1'b1;
                        r_ev_cnt <= 16'h0;
                        r_ev_num <= ev_num;
                        r_we     <= 1'b1;
                        r_addr   <= CR_ADDR;
                        r_wd     <= cfg_cr;
`ifdef TMR_CTRL_VERIFY_EN
                        r_err    <= 1'b0;
`endif
                    end
                end
`ifdef TMR_CTRL_VERIFY_EN
                // Address stays at CR for the read cycle; r_wd still holds the value just written.
                S_WR_CR: r_state <= S_RD_CR;
                S_RD_CR: begin
                    r_we <= 1'b1;
                    if (tmr_rd != r_wd) begin
                        r_err   <= 1'b1;
                        r_state <= S_STOP_CR;
                        r_addr  <= CR_ADDR;
                        r_wd    <= 32'h0;
                    end else begin
                        r_state <= S_WR_RE;
                        r_addr  <= RE_ADDR;
                        r_wd    <= w_re_ext;
                    end
                end
`else
                S_WR_CR: begin
                    r_state <= S_WR_RE;
                    r_we    <= 1'b1;
                    r_addr  <= RE_ADDR;
                    r_wd    <= w_re_ext;
                end
`endif
                S_WR_RE: r_state <= S_WAIT_IRQ;
                S_WAIT_IRQ: begin
                    if (stop) begin
                        r_state <= S_STOP_CR;
                        r_we    <= 1'b1;
                        r_addr  <= CR_ADDR;
                        r_wd    <= 32'h0;
                    end else if (tmr_irq) begin
                        r_state <= S_CLR_IR;
                        r_we    <= 1'b1;
                        r_addr  <= IR_ADDR;
                        r_wd    <= 32'h0;
                        if (r_ev_cnt != 16'hFFFF) begin
                            r_ev_cnt <= r_ev_cnt + 16'h1;
                        end
                    end
                end
                S_CLR_IR: r_state <= S_GUARD;
                S_GUARD: begin
                    if (r_ev_num != 16'h0 && r_ev_cnt == r_ev_num) begin
                        r_state <= S_STOP_CR;
                        r_we    <= 1'b1;
                        r_addr  <= CR_ADDR;
                        r_wd    <= 32'h0;
                    end else begin
                        r_state <= S_WAIT_IRQ;
                    end
                end
                S_STOP_CR: begin
                    r_state <= S_DONE;
                    r_done  <= 1'b1;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign ev_cnt   = r_ev_cnt;
    assign tmr_addr = r_addr;
    assign tmr_we   = r_we;
    assign tmr_wd   = r_wd;

endmodule

// File: tb/tb_tmr_ctrl.sv
// Directed bench for tmr_ctrl: table of complete runs plus hand sequences for stop/irq collision, restart while busy and reset.
module tb_tmr_ctrl;

    localparam logic [4:0] CR_A = 5'h00;
    localparam logic [4:0] RE_A = 5'h04;
    localparam logic [4:0] IR_A = 5'h08;
`ifdef TMR_CTRL_VERIFY_EN
    localparam int RE_GAP = 2;
`else
    localparam int RE_GAP = 1;
`endif

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        tmr_irq = 1'b0;
    logic [31:0] cfg_cr = 32'h0;
    logic [7:0]  cfg_re = 8'h0;
    logic [15:0] ev_num = 16'h0;
    logic        busy, done, err, tmr_we;
    logic [15:0] ev_cnt;
    logic [4:0]  tmr_addr;
    logic [31:0] tmr_wd, tmr_rd;
    logic [31:0] cr_model = 32'h0;
    logic        rd_flip = 1'b0;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int done_cnt = 0;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
        int          c;
    } wr_t;
    wr_t log_q[$];

    typedef struct {
        logic [31:0] cr;
        logic [7:0]  re;
        logic [15:0] evn;
        int          n_irq;
        int          gap;
        bit          use_stop;
        logic [15:0] exp_cnt;
    } vec_t;
    vec_t vecs[5];

    tmr_ctrl dut (
        .clk(clk), .rstn(rstn), .start(start), .stop(stop),
        .cfg_cr(cfg_cr), .cfg_re(cfg_re), .ev_num(ev_num),
        .busy(busy), .done(done), .err(err), .ev_cnt(ev_cnt),
        .tmr_addr(tmr_addr), .tmr_we(tmr_we), .tmr_wd(tmr_wd),
        .tmr_rd(tmr_rd), .tmr_irq(tmr_irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Minimal tmr model: remembers the last CR write and returns it (optionally corrupted) on reads.
    always @(posedge clk) if (rstn && tmr_we && tmr_addr == CR_A) cr_model <= tmr_wd;
    assign tmr_rd = rd_flip ? ~cr_model : cr_model;

    always @(negedge clk) begin
        if (rstn && tmr_we) begin
            wr_t w;
            w.a = tmr_addr;
            w.d = tmr_wd;
            w.c = cyc;
            log_q.push_back(w);
        end
        if (done) done_cnt++;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end else begin
            $display("ok   %s: %0h", nm, act);
        end
    endtask

    task automatic wait_ir(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (tmr_we && tmr_addr == IR_A) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic chk_wr(input string nm, input int i, input logic [4:0] a, input logic [31:0] d);
        if (i < log_q.size()) begin
            chk({nm, ".addr"}, 32'(log_q[i].a), 32'(a));
            chk({nm, ".data"}, log_q[i].d, d);
        end
    endtask

    task automatic do_run(input vec_t v, input int idx);
        bit    ok;
        string tag;
        int    n_exp;
        tag = $sformatf("run%0d", idx);
        log_q.delete();
        done_cnt = 0;
        cfg_cr = v.cr;
        cfg_re = v.re;
        ev_num = v.evn;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, ".busy_on"}, 32'(busy), 32'd1);
        if (v.use_stop && v.n_irq == 0) stop = 1'b1;
        for (int k = 0; k < v.n_irq; k++) begin
            repeat (v.gap) @(negedge clk);
            tmr_irq = 1'b1;
            wait_ir(ok);
            tmr_irq = 1'b0;
            if (!ok) chk($sformatf("%s.ir_timeout%0d", tag, k), 32'(ok), 32'd1);
        end
        if (v.use_stop) stop = 1'b1;
        wait_done(ok);
        stop = 1'b0;
        chk({tag, ".done_seen"}, 32'(ok), 32'd1);
        @(negedge clk);
        chk({tag, ".busy_off"}, 32'(busy), 32'd0);
        chk({tag, ".done_low"}, 32'(done), 32'd0);
        chk({tag, ".done_cnt"}, 32'(done_cnt), 32'd1);
        chk({tag, ".ev_cnt"}, 32'(ev_cnt), 32'(v.exp_cnt));
        chk({tag, ".err"}, 32'(err), 32'd0);
        n_exp = int'(v.exp_cnt) + 3;
        chk({tag, ".n_writes"}, 32'(log_q.size()), 32'(n_exp));
        chk_wr({tag, ".w_cr"}, 0, CR_A, v.cr);
        chk_wr({tag, ".w_re"}, 1, RE_A, 32'(v.re));
        if (log_q.size() >= 2) chk({tag, ".re_gap"}, 32'(log_q[1].c - log_q[0].c), 32'(RE_GAP));
        for (int i = 2; i < n_exp - 1; i++) chk_wr($sformatf("%s.w_ir%0d", tag, i - 2), i, IR_A, 32'h0);
        chk_wr({tag, ".w_stop"}, n_exp - 1, CR_A, 32'h0);
        // Interrupts after the run must not produce any bus traffic.
        tmr_irq = 1'b1;
        repeat (3) @(negedge clk);
        tmr_irq = 1'b0;
        chk({tag, ".idle_quiet"}, 32'(log_q.size()), 32'(n_exp));
    endtask

    initial begin
        bit ok;
        int n_cr;
        vecs[0] = '{cr: 32'h2,        re: 8'h50, evn: 16'd3, n_irq: 3, gap: 2, use_stop: 1'b0, exp_cnt: 16'd3};
        vecs[1] = '{cr: 32'h13,       re: 8'hAA, evn: 16'd0, n_irq: 5, gap: 1, use_stop: 1'b1, exp_cnt: 16'd5};
        vecs[2] = '{cr: 32'h7,        re: 8'h01, evn: 16'd1, n_irq: 1, gap: 0, use_stop: 1'b0, exp_cnt: 16'd1};
        vecs[3] = '{cr: 32'hFFFFFFFF, re: 8'hFF, evn: 16'd2, n_irq: 2, gap: 4, use_stop: 1'b0, exp_cnt: 16'd2};
        vecs[4] = '{cr: 32'h3,        re: 8'h10, evn: 16'd0, n_irq: 0, gap: 3, use_stop: 1'b1, exp_cnt: 16'd0};

        repeat (2) @(negedge clk);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.err", 32'(err), 32'd0);
        chk("rst.ev_cnt", 32'(ev_cnt), 32'd0);
        chk("rst.addr", 32'(tmr_addr), 32'd0);
        chk("rst.we", 32'(tmr_we), 32'd0);
        chk("rst.wd", tmr_wd, 32'd0);
        rstn = 1'b1;
        // Stop while idle must not start anything.
        stop = 1'b1;
        repeat (3) @(negedge clk);
        stop = 1'b0;
        chk("idle_stop.busy", 32'(busy), 32'd0);
        chk("idle_stop.writes", 32'(log_q.size()), 32'd0);

        for (int i = 0; i < 5; i++) do_run(vecs[i], i);

        // Stop and irq together in WAIT_IRQ: stop wins, no IR write.
        log_q.delete();
        cfg_cr = 32'h2; cfg_re = 8'h33; ev_num = 16'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (RE_GAP + 2) @(negedge clk);
        tmr_irq = 1'b1; stop = 1'b1;
        wait_done(ok);
        tmr_irq = 1'b0; stop = 1'b0;
        chk("collide.done_seen", 32'(ok), 32'd1);
        @(negedge clk);
        chk("collide.ev_cnt", 32'(ev_cnt), 32'd0);
        chk("collide.n_writes", 32'(log_q.size()), 32'd3);
        chk_wr("collide.w_stop", 2, CR_A, 32'h0);

        // Start re-pulsed while busy and ev_num changed mid-run: both ignored.
        log_q.delete();
        cfg_cr = 32'h6; cfg_re = 8'h44; ev_num = 16'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (RE_GAP + 2) @(negedge clk);
        start = 1'b1; ev_num = 16'd9;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            tmr_irq = 1'b1;
            wait_ir(ok);
            tmr_irq = 1'b0;
            if (!ok) chk($sformatf("restart.ir_timeout%0d", k), 32'(ok), 32'd1);
        end
        wait_done(ok);
        chk("restart.done_seen", 32'(ok), 32'd1);
        @(negedge clk);
        chk("restart.ev_cnt", 32'(ev_cnt), 32'd2);
        chk("restart.n_writes", 32'(log_q.size()), 32'd5);
        n_cr = 0;
        foreach (log_q[i]) if (log_q[i].a == CR_A && log_q[i].d == 32'h6) n_cr++;
        chk("restart.n_cr_prog", 32'(n_cr), 32'd1);

        // Asynchronous reset while waiting for an interrupt.
        log_q.delete();
        cfg_cr = 32'h2; cfg_re = 8'h21; ev_num = 16'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tmr_irq = 1'b1;
        wait_ir(ok);
        tmr_irq = 1'b0;
        repeat (3) @(negedge clk);
        chk("areset.pre_cnt", 32'(ev_cnt), 32'd1);
        #2 rstn = 1'b0;
        #1;
        chk("areset.busy", 32'(busy), 32'd0);
        chk("areset.ev_cnt", 32'(ev_cnt), 32'd0);
        chk("areset.we", 32'(tmr_we), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        log_q.delete();
        tmr_irq = 1'b1; stop = 1'b1;
        repeat (8) @(negedge clk);
        tmr_irq = 1'b0; stop = 1'b0;
        chk("areset.quiet", 32'(log_q.size()), 32'd0);
        chk("areset.busy_after", 32'(busy), 32'd0);

`ifdef TMR_CTRL_VERIFY_EN
        // Corrupted CR readback aborts straight to the disable write.
        log_q.delete();
        rd_flip = 1'b1;
        cfg_cr = 32'h5; cfg_re = 8'h66; ev_num = 16'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(ok);
        chk("vfy_bad.done_seen", 32'(ok), 32'd1);
        @(negedge clk);
        rd_flip = 1'b0;
        chk("vfy_bad.err", 32'(err), 32'd1);
        chk("vfy_bad.busy", 32'(busy), 32'd0);
        chk("vfy_bad.n_writes", 32'(log_q.size()), 32'd2);
        chk_wr("vfy_bad.w_cr", 0, CR_A, 32'h5);
        chk_wr("vfy_bad.w_stop", 1, CR_A, 32'h0);
        do_run(vecs[0], 9);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
